// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   DATA_W  : operand/result width (only 32 is supported)
//   ITER    : iterations per multiply or divide (one bit per edge)
//   state_t : control FSM encoding
//   abs_val : two's-complement magnitude (0x80000000 maps to itself,
//             which reads correctly as an unsigned magnitude)
package mdu_pkg;

  localparam int DATA_W = 32;
  localparam int ITER   = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MULT_RUN = 2'b01,
    DIV_RUN  = 2'b10,
    DONE     = 2'b11
  } state_t;

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? -x : x;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Control-unit <-> multiply/divide unit handshake.
//   start_mult, start_div : one-cycle requests from the control unit
//   op_a, op_b            : rs/rt operands (multiplicand/dividend, multiplier/divisor)
//   hi_out, lo_out        : architectural HI/LO registers
//   busy, done, div_zero  : status back to the control unit
// master = control unit side, slave = the unit itself.
interface mdu_if;
  import mdu_pkg::*;

  logic              start_mult;
  logic              start_div;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;
  logic              busy;
  logic              done;
  logic              div_zero;

  modport master (
    output start_mult, start_div, op_a, op_b,
    input  hi_out, lo_out, busy, done, div_zero
  );

  modport slave (
    input  start_mult, start_div, op_a, op_b,
    output hi_out, lo_out, busy, done, div_zero
  );
endinterface

// File: rtl/mdu_div_core.sv
// Restoring divider on operand magnitudes with sign fix-up.
//   clk, reset          : clock, async active-high reset
//   load                : capture |dividend|, |divisor| and the result signs
//   step                : perform one shift/subtract/restore iteration
//   dividend, divisor   : signed operands (sampled on load)
//   quotient, remainder : signed results as they stand after the step in
//                         progress; the owner latches them on the last step
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [DATA_W-1:0] rem_q, quo_q, dsr_q;
  logic              neg_q, neg_r;

  // Partial remainder always stays below the divisor (<= 2^31), so the
  // shifted value fits DATA_W+1 bits and the top bit of diff is the borrow.
  logic [DATA_W:0]   shifted, diff;
  logic [DATA_W-1:0] rem_nx, quo_nx;

  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign diff    = shifted - {1'b0, dsr_q};
  assign rem_nx  = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quo_nx  = {quo_q[DATA_W-2:0], ~diff[DATA_W]};

  // Truncating division: quotient sign is sign(a)^sign(b), remainder follows a.
  assign quotient  = neg_q ? -quo_nx : quo_nx;
  assign remainder = neg_r ? -rem_nx : rem_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= abs_val(dividend);
      dsr_q <= abs_val(divisor);
      neg_q <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
      neg_r <= dividend[DATA_W-1];
    end else if (step) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit (MULT/DIV) for the multicycle MIPS.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : mdu_if slave (starts, operands, HI/LO, busy/done/div_zero)
// Multiply is radix-2 Booth held in this module; divide lives in mdu_div_core.
// Both take 32 iteration edges after the start edge; divide by zero finishes
// on the start edge itself and leaves HI/LO untouched.
module mult_div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);
  import mdu_pkg::*;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   acc;      // one guard bit so subtracting M=-2^31 cannot overflow
  logic [DATA_W-1:0] q, m;
  logic              q_m1;
  logic [DATA_W-1:0] div_quo, div_rem;
  logic              div_load, div_step, last;

  // Booth step: add/sub M on {Q0,Q-1}, then arithmetic shift of {acc,Q,Q-1}.
  logic [DATA_W:0]   booth_sum, acc_nx;
  logic [DATA_W-1:0] q_nx;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    booth_sum = acc;
    unique case ({q[0], q_m1})
      2'b01:   booth_sum = acc + {m[DATA_W-1], m};
      2'b10:   booth_sum = acc - {m[DATA_W-1], m};
      default: booth_sum = acc;
    endcase
  end

  assign acc_nx = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
  assign q_nx   = {booth_sum[0], q[DATA_W-1:1]};
  assign last   = (cnt == CNT_W'(ITER - 1));

  // start_mult wins a tie, so a divide only loads when it is the sole request.
  assign div_load = (state == IDLE) && bus.start_div && !bus.start_mult && (bus.op_b != '0);
  assign div_step = (state == DIV_RUN);

  mdu_div_core u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (bus.op_a),
    .divisor   (bus.op_b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= '0;
      q            <= '0;
      m            <= '0;
      q_m1         <= 1'b0;
      bus.hi_out   <= '0;
      bus.lo_out   <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start_mult) begin
            acc          <= '0;
            q            <= bus.op_b;
            q_m1         <= 1'b0;
            m            <= bus.op_a;
            cnt          <= '0;
            bus.busy     <= 1'b1;
            bus.div_zero <= 1'b0;
            state        <= MULT_RUN;
          end else if (bus.start_div) begin
            cnt <= '0;
            if (bus.op_b == '0) begin
              bus.div_zero <= 1'b1;
              bus.done     <= 1'b1;
              state        <= DONE;
            end else begin
              bus.div_zero <= 1'b0;
              bus.busy     <= 1'b1;
              state        <= DIV_RUN;
            end
          end
        end
        MULT_RUN: begin
          acc  <= acc_nx;
          q    <= q_nx;
          q_m1 <= q[0];
          if (last) begin
            bus.hi_out <= acc_nx[DATA_W-1:0];
            bus.lo_out <= q_nx;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV_RUN: begin
          if (last) begin
            bus.hi_out <= div_rem;
            bus.lo_out <= div_quo;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// MULT/DIV traffic compared against 64-bit integer arithmetic.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mdu_if bus ();

  mult_div_unit #(.DATA_W(32), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One operation from start pulse to the cycle after done.
  // is_div/both choose the request lines; poke fires a stray start_mult mid-run.
  task automatic run_op(input bit is_div, input bit both, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    longint sa, sb, res_q, res_r, prod;
    logic [31:0] eh, el;
    bit ez;
    int lat, k;

    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ez = 1'b0;
    if (is_div && !both) begin
      if (b == 32'd0) begin
        ez = 1'b1; eh = exp_hi; el = exp_lo; lat = 0;
      end else begin
        res_q = sa / sb;
        res_r = sa % sb;
        el = res_q[31:0]; eh = res_r[31:0]; lat = 32;
      end
    end else begin
      prod = sa * sb;
      eh = prod[63:32]; el = prod[31:0]; lat = 32;
    end

    @(negedge clk);
    bus.start_mult = !is_div || both;
    bus.start_div  = is_div;
    bus.op_a = a;
    bus.op_b = b;
    @(negedge clk);
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.op_a = $urandom;
    bus.op_b = $urandom;

    k = 0;
    while (!bus.done && k < 40) begin
      if (k == 0) begin
        check("busy_after_start", {63'd0, bus.busy}, 64'd1);
        check("dz_clear", {63'd0, bus.div_zero}, 64'd0);
      end
      bus.start_mult = poke && (k == 5);
      if (poke && k == 5) begin
        bus.op_a = $urandom;
        bus.op_b = $urandom;
      end
      @(negedge clk);
      k++;
    end
    bus.start_mult = 1'b0;

    check("latency", 64'(k), 64'(lat));
    check("busy_at_done", {63'd0, bus.busy}, 64'd0);
    check("hi", {32'd0, bus.hi_out}, {32'd0, eh});
    check("lo", {32'd0, bus.lo_out}, {32'd0, el});
    check("div_zero", {63'd0, bus.div_zero}, {63'd0, ez});

    // A start during DONE must be dropped.
    bus.start_div = 1'b1;
    bus.op_b = 32'd3;
    @(negedge clk);
    bus.start_div = 1'b0;
    check("done_one_cycle", {63'd0, bus.done}, 64'd0);
    check("ignored_in_done", {63'd0, bus.busy}, 64'd0);
    check("dz_sticky", {63'd0, bus.div_zero}, {63'd0, ez});
    exp_hi = eh;
    exp_lo = el;
  endtask

  initial begin
    int seen_done, kind;
    logic [31:0] ra, rb;

    reset = 1'b1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", {32'd0, bus.hi_out}, 64'd0);
    check("rst_lo", {32'd0, bus.lo_out}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_dz", {63'd0, bus.div_zero}, 64'd0);
    reset = 1'b0;

    // Directed cases.
    run_op(1'b0, 1'b0, 32'h7, 32'hFFFF_FFFD, 1'b0);
    check("mult_7x-3_hi", {32'd0, bus.hi_out}, 64'hFFFF_FFFF);
    check("mult_7x-3_lo", {32'd0, bus.lo_out}, 64'hFFFF_FFEB);
    run_op(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("mult_min_sq_hi", {32'd0, bus.hi_out}, 64'h4000_0000);
    run_op(1'b0, 1'b0, 32'h1234_5678, 32'h0, 1'b0);
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'h2, 1'b0);
    check("div_-7/2_lo", {32'd0, bus.lo_out}, 64'hFFFF_FFFD);
    check("div_-7/2_hi", {32'd0, bus.hi_out}, 64'hFFFF_FFFF);
    run_op(1'b1, 1'b0, 32'd100, 32'hFFFF_FFF9, 1'b0);
    check("div_100/-7_lo", {32'd0, bus.lo_out}, 64'hFFFF_FFF2);
    check("div_100/-7_hi", {32'd0, bus.hi_out}, 64'h2);
    run_op(1'b0, 1'b0, 32'h0001_2345, 32'hFFF0_0001, 1'b0);
    run_op(1'b1, 1'b0, 32'd5, 32'd0, 1'b0);
    run_op(1'b0, 1'b0, 32'd9, 32'd11, 1'b0);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_wrap_lo", {32'd0, bus.lo_out}, 64'h8000_0000);
    check("div_wrap_hi", {32'd0, bus.hi_out}, 64'h0);
    run_op(1'b1, 1'b1, 32'd6, 32'd7, 1'b0);
    check("both_starts_mult", {32'd0, bus.lo_out}, 64'd42);
    run_op(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_1001, 1'b1);
    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0013, 1'b1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.start_mult = 1'b1;
    bus.op_a = 32'h0BAD_F00D;
    bus.op_b = 32'h0000_0777;
    @(negedge clk);
    bus.start_mult = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_hi", {32'd0, bus.hi_out}, 64'd0);
    check("mid_rst_lo", {32'd0, bus.lo_out}, 64'd0);
    check("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
    check("mid_rst_done", {63'd0, bus.done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done++;
    end
    check("no_done_after_abort", 64'(seen_done), 64'd0);

    // Random traffic.
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 3);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 2) == 0) rb = {{24{rb[31]}}, rb[7:0]};
      if (kind == 3) rb = 32'd0;
      run_op(kind != 0, 1'b0, ra, rb, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
